// File: rtl/mux_ctrl_pkg.sv
// Shared arbitration types and the rotate-priority pick function.
// Latency: combinational helpers only.
// Backpressure: not applicable (no handshake in this package).
package mux_ctrl_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Widest requester vector the pick function supports.
    localparam int MAX_W     = 32;
    localparam int IDX_MAX_W = 5;

    typedef struct packed {
        logic                 found;
        logic [IDX_MAX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping at width.
    // The loop visits MAX_W positions; when width < MAX_W positions repeat,
    // which is harmless because only the first hit is recorded.
    // ptr must be below width.
    function automatic rr_pick_t rr_pick(input logic [MAX_W-1:0]     req,
                                         input logic [IDX_MAX_W-1:0] ptr,
                                         input logic [IDX_MAX_W:0]   width);
        rr_pick_t             r;
        logic [IDX_MAX_W:0]   j;
        r = '0;
        j = {1'b0, ptr};
        for (int i = 0; i < MAX_W; i++) begin
            if (!r.found && req[j[IDX_MAX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[IDX_MAX_W-1:0];
            end
            j = j + (IDX_MAX_W+1)'(1);
            if (j >= width) begin
                j = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/select bundle between the arbiter, its sources and the mux consumer.
// Latency: wires only.
// Backpressure: out_ready from the consumer; req is a level held while a source has data.
// Ports: req, out_ready (into arbiter); select, grant_id, out_valid, busy (out of arbiter).
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 4
) ();
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] req;
    logic             out_ready;
    logic [WIDTH-1:0] select;
    logic [IDX_W-1:0] grant_id;
    logic             out_valid;
    logic             busy;

    // Arbiter side.
    modport master (
        input  req, out_ready,
        output select, grant_id, out_valid, busy
    );

    // Sources / consumer side.
    modport slave (
        output req, out_ready,
        input  select, grant_id, out_valid, busy
    );
endinterface

// File: rtl/rr_pick_onehot.sv
// Rotate-priority encoder: first requester at or after ptr_i, as index and one-hot.
// Latency: combinational.
// Backpressure: none.
// Ports: req_i, ptr_i in; found_o, idx_o, onehot_o out.
module rr_pick_onehot
    import mux_ctrl_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] onehot_o
);
    rr_pick_t pick;

    // Upper index bits are always zero for WIDTH below MAX_W.
    logic unused_idx_bits;
    assign unused_idx_bits = ^pick.idx;

    always_comb begin
        pick     = rr_pick(MAX_W'(req_i), IDX_MAX_W'(ptr_i), (IDX_MAX_W+1)'(WIDTH));
        found_o  = pick.found;
        idx_o    = pick.idx[IDX_W-1:0];
        onehot_o = '0;
        if (pick.found) begin
            onehot_o[pick.idx[IDX_W-1:0]] = 1'b1;
        end
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter holding a one-hot mux select for bursts of up to BURST transfers.
// Latency: 1 cycle from request to select; 1 idle cycle (select=0) between grants.
// Backpressure: out_ready low stalls the burst counter and holds the grant.
// Ports: clk, rst_n (async, active-low); bus (master modport) carries req/out_ready in,
//        select/grant_id/out_valid/busy out.
module mux_rr_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(BURST + 1);

    arb_state_t       state_q;
    logic [WIDTH-1:0] select_q;
    logic [IDX_W-1:0] grant_id_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_onehot;
    logic             granted_req;
    logic             xfer;
    logic             burst_done;

    rr_pick_onehot #(.WIDTH(WIDTH)) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .found_o  (win_found),
        .idx_o    (win_idx),
        .onehot_o (win_onehot)
    );

    // Only the granted source's request matters; other sources cannot disturb a grant.
    assign granted_req   = bus.req[grant_id_q];
    assign bus.out_valid = (state_q == GRANT) && granted_req;
    assign xfer          = bus.out_valid && bus.out_ready;
    assign burst_done    = xfer && (cnt_q == CNT_W'(BURST - 1));

    assign bus.select    = select_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q == GRANT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            select_q   <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q    <= GRANT;
                        select_q   <= win_onehot;
                        grant_id_q <= win_idx;
                        cnt_q      <= '0;
                        // Winner drops to lowest priority for the next search.
                        ptr_q      <= (win_idx == IDX_W'(WIDTH - 1)) ? '0 : win_idx + IDX_W'(1);
                    end
                end
                GRANT: begin
                    // Every re-arbitration goes through IDLE, giving one select=0 cycle.
                    if (!granted_req || burst_done) begin
                        state_q    <= IDLE;
                        select_q   <= '0;
                        grant_id_q <= '0;
                        cnt_q      <= '0;
                    end else if (xfer) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    select_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   xfers;
    logic mon_en;

    mux_rr_arbiter_if #(.WIDTH(4)) bus ();

    mux_rr_arbiter #(.WIDTH(4), .BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // select must never carry more than one bit.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert ($onehot0(bus.select)) else begin
                errors++;
                $error("FAIL onehot0 observed=%b expected=at most one bit", bus.select);
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        xfers         = 0;
        mon_en        = 1'b0;
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b0;

        // Reset held with all requests pending.
        step();
        step();
        mon_en = 1'b1;
        chk("rst_select", 32'(bus.select), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_gid", 32'(bus.grant_id), 32'h0);

        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("first_select", 32'(bus.select), 32'h1);
        chk("first_gid", 32'(bus.grant_id), 32'h0);

        // Fairness: 0,1,2,3,0 with 4 transfers then one idle cycle each.
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 4; k++) begin
                chk("fair_select", 32'(bus.select), 32'(1) << (n % 4));
                chk("fair_gid", 32'(bus.grant_id), 32'(n % 4));
                chk("fair_valid", 32'(bus.out_valid), 32'h1);
                step();
            end
            chk("fair_gap_select", 32'(bus.select), 32'h0);
            chk("fair_gap_busy", 32'(bus.busy), 32'h0);
            step();
        end
        chk("fair_next_select", 32'(bus.select), 32'h2);

        // Early release: drop granted source 1, then grant 2.
        bus.req = 4'b0100;
        #1;
        chk("drop_valid", 32'(bus.out_valid), 32'h0);
        step();
        chk("drop_idle_select", 32'(bus.select), 32'h0);
        step();
        chk("grant2_select", 32'(bus.select), 32'h4);
        step();
        step();
        chk("grant2_held", 32'(bus.select), 32'h4);
        // Drop with out_ready high: no transfer, back to IDLE, next is source 3.
        bus.req = 4'b1011;
        #1;
        chk("drop2_valid", 32'(bus.out_valid), 32'h0);
        step();
        chk("drop2_idle", 32'(bus.select), 32'h0);
        step();
        chk("grant3_select", 32'(bus.select), 32'h8);
        chk("grant3_gid", 32'(bus.grant_id), 32'h3);

        // Backpressure: 10 stalled cycles hold the grant, then exactly 4 transfers.
        bus.req       = 4'b1000;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_select", 32'(bus.select), 32'h8);
            if (bus.out_valid && bus.out_ready) xfers++;
            step();
        end
        chk("bp_stall_xfers", 32'(xfers), 32'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && bus.busy; i++) begin
            if (bus.out_valid && bus.out_ready) xfers++;
            step();
        end
        chk("bp_xfers", 32'(xfers), 32'h4);
        chk("bp_end_busy", 32'(bus.busy), 32'h0);

        // Wrap: get pointer to 3 by granting 2, then req=0101 must pick 0.
        bus.req = 4'b0100;
        step();
        chk("wrap_g2", 32'(bus.select), 32'h4);
        bus.req = 4'b0000;
        step();
        chk("wrap_idle", 32'(bus.busy), 32'h0);
        bus.req = 4'b0101;
        step();
        chk("wrap_select", 32'(bus.select), 32'h1);
        chk("wrap_gid", 32'(bus.grant_id), 32'h0);
        bus.req = 4'b0100;
        step();
        chk("wrap_idle2", 32'(bus.select), 32'h0);
        step();
        chk("wrap_g2b_select", 32'(bus.select), 32'h4);
        chk("wrap_g2b_gid", 32'(bus.grant_id), 32'h2);

        // Async reset after 2 transfers; restart must favour source 0 over 3.
        step();
        step();
        chk("mid_select", 32'(bus.select), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("arst_select", 32'(bus.select), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_gid", 32'(bus.grant_id), 32'h0);
        bus.req = 4'b1001;
        step();
        chk("arst_hold", 32'(bus.select), 32'h0);
        rst_n = 1'b1;
        step();
        chk("restart_select", 32'(bus.select), 32'h1);
        chk("restart_gid", 32'(bus.grant_id), 32'h0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
